// File: rtl/mlp_layer_sequencer_if.sv
// Bundle of the host, layer and result handshake signals of the
// two-layer MLP sequencer; the slave side is the sequencer itself.
interface mlp_layer_sequencer_if #(
    parameter int DATA_WIDTH  = 20,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_HIDDEN  = 8,
    parameter int NUM_OUTPUTS = 3,
    parameter int ERRW        = 8
);
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_WIDTH*NUM_INPUTS-1:0]  in_data;
    logic                              hid_start;
    logic [DATA_WIDTH*NUM_INPUTS-1:0]  hid_inputs;
    logic [DATA_WIDTH*NUM_HIDDEN-1:0]  hid_outputs;
    logic                              hid_valid;
    logic                              out_start;
    logic [DATA_WIDTH*NUM_HIDDEN-1:0]  out_inputs;
    logic [DATA_WIDTH*NUM_OUTPUTS-1:0] out_outputs;
    logic                              out_valid;
    logic                              res_valid;
    logic                              res_ready;
    logic [DATA_WIDTH*NUM_OUTPUTS-1:0] res_data;
    logic                              busy;
    logic                              timeout_err;
    logic [ERRW-1:0]                   err_count;

    modport master (
        output in_valid, in_data, hid_outputs, hid_valid,
        output out_outputs, out_valid, res_ready,
        input  in_ready, hid_start, hid_inputs, out_start,
        input  out_inputs, res_valid, res_data, busy,
        input  timeout_err, err_count
    );

    modport slave (
        input  in_valid, in_data, hid_outputs, hid_valid,
        input  out_outputs, out_valid, res_ready,
        output in_ready, hid_start, hid_inputs, out_start,
        output out_inputs, res_valid, res_data, busy,
        output timeout_err, err_count
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Runs one inference through a hidden then an output dense layer,
// with a per-layer watchdog and a saturating abort counter.
module mlp_layer_sequencer #(
    parameter int DATA_WIDTH  = 20,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_HIDDEN  = 8,
    parameter int NUM_OUTPUTS = 3,
    parameter int TIMEOUT     = 1023,
    parameter int ERRW        = 8
) (
    input logic                  clk,
    input logic                  rst,
    mlp_layer_sequencer_if.slave bus
);
    localparam int IW  = DATA_WIDTH * NUM_INPUTS;
    localparam int HW  = DATA_WIDTH * NUM_HIDDEN;
    localparam int OW  = DATA_WIDTH * NUM_OUTPUTS;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0]  WD_MAX  = WDW'(TIMEOUT);
    localparam logic [ERRW-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HID_START,
        S_HID_WAIT,
        S_OUT_START,
        S_OUT_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            hid_prev_q, out_prev_q;
    logic [IW-1:0]   hid_inputs_q, hid_inputs_d;
    logic [HW-1:0]   out_inputs_q, out_inputs_d;
    logic [OW-1:0]   res_data_q, res_data_d;
    logic            in_ready_q, in_ready_d;
    logic            hid_start_q, hid_start_d;
    logic            out_start_q, out_start_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;
    logic            timeout_err_q, timeout_err_d;
    logic [ERRW-1:0] err_count_q, err_count_d;
    logic            hid_rise, out_rise, abort;

    // A level left high from the previous inference must not count.
    assign hid_rise = bus.hid_valid & ~hid_prev_q;
    assign out_rise = bus.out_valid & ~out_prev_q;

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        hid_inputs_d  = hid_inputs_q;
        out_inputs_d  = out_inputs_q;
        res_data_d    = res_data_q;
        err_count_d   = err_count_q;
        timeout_err_d = 1'b0;
        abort         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    hid_inputs_d = bus.in_data;
                    state_d      = S_HID_START;
                end
            end
            S_HID_START: begin
                wd_d    = '0;
                state_d = S_HID_WAIT;
            end
            S_HID_WAIT: begin
                if (hid_rise) begin
                    out_inputs_d = bus.hid_outputs;
                    state_d      = S_OUT_START;
                end else if (wd_q == WD_MAX) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_OUT_START: begin
                wd_d    = '0;
                state_d = S_OUT_WAIT;
            end
            S_OUT_WAIT: begin
                if (out_rise) begin
                    res_data_d = bus.out_outputs;
                    state_d    = S_DONE;
                end else if (wd_q == WD_MAX) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + ERRW'(1);
            end
        end

        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        hid_start_d = (state_d == S_HID_START);
        out_start_d = (state_d == S_OUT_START);
        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wd_q          <= '0;
            hid_prev_q    <= 1'b0;
            out_prev_q    <= 1'b0;
            hid_inputs_q  <= '0;
            out_inputs_q  <= '0;
            res_data_q    <= '0;
            in_ready_q    <= 1'b1;
            hid_start_q   <= 1'b0;
            out_start_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            hid_prev_q    <= bus.hid_valid;
            out_prev_q    <= bus.out_valid;
            hid_inputs_q  <= hid_inputs_d;
            out_inputs_q  <= out_inputs_d;
            res_data_q    <= res_data_d;
            in_ready_q    <= in_ready_d;
            hid_start_q   <= hid_start_d;
            out_start_q   <= out_start_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.hid_start   = hid_start_q;
    assign bus.hid_inputs  = hid_inputs_q;
    assign bus.out_start   = out_start_q;
    assign bus.out_inputs  = out_inputs_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: behavioural layer stubs, a cycle
// reference model and directed nominal/stall/timeout/reset scenarios.
module tb_mlp_layer_sequencer;
    localparam int DW = 20;
    localparam int NI = 4;
    localparam int NH = 8;
    localparam int NO = 3;
    localparam int TO = 15;
    localparam int EW = 2;
    localparam int LH = 5;
    localparam int LO = 7;
    localparam int ERR_SAT = (1 << EW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_HS   = 1;
    localparam int P_HW   = 2;
    localparam int P_OS   = 3;
    localparam int P_OW   = 4;
    localparam int P_DONE = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_HIDDEN(NH),
        .NUM_OUTPUTS(NO), .ERRW(EW)
    ) bus ();

    mlp_layer_sequencer #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_HIDDEN(NH),
        .NUM_OUTPUTS(NO), .TIMEOUT(TO), .ERRW(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Layer stub controls: hmode 0 normal, 1 never answers, 2 level from hlvl.
    int hmode = 0;
    logic hlvl = 1'b0;
    int hcnt = 0;
    int ocnt = 0;
    logic [DW*NH-1:0] hpat = '0;
    logic [DW*NO-1:0] opat = '0;

    always @(negedge clk) begin
        bus.hid_outputs <= hpat;
        if (rst) begin
            hcnt <= 0;
            bus.hid_valid <= 1'b0;
        end else if (hmode == 2) begin
            bus.hid_valid <= hlvl;
        end else if (bus.hid_start) begin
            bus.hid_valid <= 1'b0;
            hcnt <= (hmode == 0) ? LH : 0;
        end else if (hcnt == 1) begin
            hcnt <= 0;
            bus.hid_valid <= 1'b1;
        end else if (hcnt > 1) begin
            hcnt <= hcnt - 1;
        end
    end

    always @(negedge clk) begin
        bus.out_outputs <= opat;
        if (rst) begin
            ocnt <= 0;
            bus.out_valid <= 1'b0;
        end else if (bus.out_start) begin
            bus.out_valid <= 1'b0;
            ocnt <= LO;
        end else if (ocnt == 1) begin
            ocnt <= 0;
            bus.out_valid <= 1'b1;
        end else if (ocnt > 1) begin
            ocnt <= ocnt - 1;
        end
    end

    int n_hs = 0;
    int n_os = 0;
    int n_rv = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.hid_start) n_hs <= n_hs + 1;
            if (bus.out_start) n_os <= n_os + 1;
            if (bus.res_valid) n_rv <= n_rv + 1;
        end
    end

    // Reference: which phase of the inference we are in, plus the data
    // that each phase hands on.
    int m_ph = P_IDLE;
    int m_wait = 0;
    int m_err = 0;
    logic m_hp = 1'b0;
    logic m_op = 1'b0;
    logic m_terr = 1'b0;
    logic [DW*NI-1:0] m_hin = '0;
    logic [DW*NH-1:0] m_oin = '0;
    logic [DW*NO-1:0] m_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= P_IDLE; m_wait <= 0; m_err <= 0;
            m_hp <= 1'b0; m_op <= 1'b0; m_terr <= 1'b0;
            m_hin <= '0; m_oin <= '0; m_res <= '0;
        end else begin
            m_hp <= bus.hid_valid;
            m_op <= bus.out_valid;
            m_terr <= 1'b0;
            case (m_ph)
                P_IDLE: if (bus.in_valid) begin
                    m_hin <= bus.in_data; m_ph <= P_HS;
                end
                P_HS, P_OS: begin
                    m_wait <= 0; m_ph <= m_ph + 1;
                end
                P_HW, P_OW: begin
                    if (m_ph == P_HW && bus.hid_valid && !m_hp) begin
                        m_oin <= bus.hid_outputs; m_ph <= P_OS;
                    end else if (m_ph == P_OW && bus.out_valid && !m_op) begin
                        m_res <= bus.out_outputs; m_ph <= P_DONE;
                    end else if (m_wait == TO) begin
                        m_terr <= 1'b1; m_ph <= P_IDLE;
                        m_err <= (m_err == ERR_SAT) ? ERR_SAT : m_err + 1;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                default: if (bus.res_ready) m_ph <= P_IDLE;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            chk("in_ready", 256'(bus.in_ready), 256'(m_ph == P_IDLE));
            chk("busy", 256'(bus.busy), 256'(m_ph != P_IDLE));
            chk("hid_start", 256'(bus.hid_start), 256'(m_ph == P_HS));
            chk("out_start", 256'(bus.out_start), 256'(m_ph == P_OS));
            chk("res_valid", 256'(bus.res_valid), 256'(m_ph == P_DONE));
            chk("timeout_err", 256'(bus.timeout_err), 256'(m_terr));
            chk("err_count", 256'(bus.err_count), 256'(m_err));
            chk("res_data", 256'(bus.res_data), 256'(m_res));
            chk("hid_inputs", 256'(bus.hid_inputs), 256'(m_hin));
            chk("out_inputs", 256'(bus.out_inputs), 256'(m_oin));
        end
    endtask

    // sel 0: res_valid, 1: timeout_err, 2: out_start; n = -1 on expiry.
    task automatic run_until(input int sel, input int bound, output int n);
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < bound) begin
            tick();
            n++;
            if (n == 1) bus.in_valid = 1'b0;
            case (sel)
                0: hit = bus.res_valid;
                1: hit = bus.timeout_err;
                default: hit = bus.out_start;
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 256'(bus.in_ready), 256'(1));
        chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
        chk({tag, "_hid_start"}, 256'(bus.hid_start), 256'(0));
        chk({tag, "_out_start"}, 256'(bus.out_start), 256'(0));
        chk({tag, "_res_valid"}, 256'(bus.res_valid), 256'(0));
        chk({tag, "_timeout_err"}, 256'(bus.timeout_err), 256'(0));
        chk({tag, "_err_count"}, 256'(bus.err_count), 256'(0));
        chk({tag, "_res_data"}, 256'(bus.res_data), 256'(0));
        chk({tag, "_hid_inputs"}, 256'(bus.hid_inputs), 256'(0));
        chk({tag, "_out_inputs"}, 256'(bus.out_inputs), 256'(0));
    endtask

    localparam logic [DW*NI-1:0] V_NOM = {4{20'h10000}};
    localparam logic [DW*NI-1:0] V_2 = 80'h00001000020000300004;
    localparam logic [DW*NI-1:0] V_4 = 80'h0ABCD12345FFFFF00000;
    localparam logic [DW*NH-1:0] H_1 =
        160'h0123456789ABCDEF00112233445566778899AABB;
    localparam logic [DW*NH-1:0] H_2 =
        160'hCAFEF00D00000000FFFFFFFF1234567800000001;
    localparam logic [DW*NO-1:0] O_1 = 60'hFEDCBA987654321;
    localparam logic [DW*NO-1:0] O_2 = 60'h0A0B0C0D0E0F123;
    localparam logic [DW*NO-1:0] O_3 = 60'h123456789ABCDEF;

    int exp_err[5] = '{1, 2, 3, 3, 3};

    initial begin
        int n;
        int hs1;
        int os1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.res_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Five back-to-back hidden-layer timeouts: pulse 2 + 16 cycles
        // after the accept cycle, counter saturates at 3 with ERRW=2.
        hmode = 1;
        for (int r = 0; r < 5; r++) begin
            bus.in_data = V_2;
            bus.in_valid = 1'b1;
            run_until(1, 40, n);
            chk("timeout_lat", 256'(n), 256'(18));
            chk("timeout_errcnt", 256'(bus.err_count), 256'(exp_err[r]));
            tick();
            chk("timeout_idle", 256'(bus.in_ready), 256'(1));
        end
        chk("timeout_no_res", 256'(n_rv), 256'(0));

        rst = 1'b1;
        tick();
        chk("rst_clears_err", 256'(bus.err_count), 256'(0));
        rst = 1'b0;

        // Nominal inference followed by 20 cycles of result backpressure.
        hmode = 0;
        hpat = H_1;
        opat = O_1;
        hs1 = n_hs;
        os1 = n_os;
        bus.in_data = V_NOM;
        bus.in_valid = 1'b1;
        run_until(0, 60, n);
        chk("nom_latency", 256'(n), 256'(15));
        chk("nom_res_data", 256'(bus.res_data), 256'(O_1));
        chk("nom_hid_inputs", 256'(bus.hid_inputs), 256'(V_NOM));
        chk("nom_out_inputs", 256'(bus.out_inputs), 256'(H_1));
        chk("nom_hs_pulses", 256'(n_hs - hs1), 256'(1));
        chk("nom_os_pulses", 256'(n_os - os1), 256'(1));
        repeat (20) tick();
        chk("bp_res_valid", 256'(bus.res_valid), 256'(1));
        chk("bp_res_data", 256'(bus.res_data), 256'(O_1));
        chk("bp_in_ready", 256'(bus.in_ready), 256'(0));

        // Release with a new vector already offered; it must wait a cycle.
        hmode = 2;
        hlvl = 1'b1;
        hpat = H_2;
        opat = O_2;
        bus.res_ready = 1'b1;
        bus.in_data = V_2;
        bus.in_valid = 1'b1;
        tick();
        chk("rel_res_valid", 256'(bus.res_valid), 256'(0));
        chk("rel_in_ready", 256'(bus.in_ready), 256'(1));
        hs1 = n_hs;
        os1 = n_os;
        tick();
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b0;

        // hid_valid still high from the previous run: must stall.
        repeat (6) tick();
        chk("stale_hs", 256'(n_hs - hs1), 256'(1));
        chk("stale_no_os", 256'(n_os - os1), 256'(0));
        chk("stale_busy", 256'(bus.busy), 256'(1));
        hlvl = 1'b0;
        repeat (2) tick();
        hlvl = 1'b1;
        run_until(0, 60, n);
        chk("stale_done", 256'(n > 0), 256'(1));
        chk("stale_res_data", 256'(bus.res_data), 256'(O_2));
        chk("stale_out_inputs", 256'(bus.out_inputs), 256'(H_2));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        hmode = 0;

        // Asynchronous reset while waiting on the output layer.
        bus.in_data = V_4;
        bus.in_valid = 1'b1;
        run_until(2, 40, n);
        chk("ar_reach_out", 256'(n > 0), 256'(1));
        repeat (3) tick();
        chk("ar_in_out_wait", 256'(bus.busy), 256'(1));
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        tick();
        tick();
        rst = 1'b0;

        opat = O_3;
        bus.in_data = V_4;
        bus.in_valid = 1'b1;
        run_until(0, 60, n);
        chk("post_rst_latency", 256'(n), 256'(15));
        chk("post_rst_res_data", 256'(bus.res_data), 256'(O_3));
        chk("post_rst_hid_inputs", 256'(bus.hid_inputs), 256'(V_4));
        bus.res_ready = 1'b1;
        tick();
        chk("post_rst_release", 256'(bus.in_ready), 256'(1));
        bus.res_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
